ofm_pack_drain: RTL and testbench
=================================

# ofm_pack_drain

Controller that owns port A of the output-feature-map BRAM (64-bit words, 10 entries, 1-cycle read latency, write-or-read per enabled cycle). It packs the 8-bit quantized OFM pixel stream from the activation stage into 64-bit words and writes them at consecutive addresses. On tile end or buffer full, it reads the words back and drains them to a 64-bit AXI-Stream master feeding the output DMA.

## Interface
- DATA_W, 8, pixel width
- LANES, 8, pixels per BRAM word; RAM_WIDTH = DATA_W*LANES = 64
- RAM_DEPTH, 10, BRAM entries per chunk
- ADDR_W, 4, BRAM address width, $clog2(RAM_DEPTH)
- clka  in  1  single clock; all state on rising edge
- rsta  in  1  reset, asynchronous, active-high
- s_pix_data  in  DATA_W  pixel
- s_pix_valid  in  1  pixel valid
- s_pix_last  in  1  last pixel of tile; qualified by valid
- s_pix_ready  out  1  block accepts pixel
- bram_addra  out  ADDR_W  BRAM address
- bram_dina  out  RAM_WIDTH  BRAM write data
- bram_wea  out  1  BRAM write enable
- bram_ena  out  1  BRAM enable
- bram_regcea  out  1  tied 1
- bram_douta  in  RAM_WIDTH  BRAM read data, valid the cycle after a read-enabled cycle
- m_tdata  out  RAM_WIDTH  drained word
- m_tvalid  out  1  word valid
- m_tlast  out  1  last word of chunk
- m_tready  in  1  downstream accepts
- tile_done  out  1  one-cycle pulse: drain of a last-terminated chunk complete

## Operation
- Handshakes: a pixel is accepted on valid&ready; a beat transfers on tvalid&tready. Packing: lane 0 -> bits [7:0], lane k -> bits [8k+7:8k]. Unused lanes are zero.
- States: IDLE, FILL, FLUSH, RD, OUT, DONE.
- IDLE -> FILL unconditionally. Entered only from reset.
- FILL: s_pix_ready=1. Each accept stores the pixel into the pack register at lane_cnt, then increments lane_cnt.
  - On accept with lane_cnt==7 or last, the word is closed: the word register is loaded, the write-pending flag is set, the pack register is cleared, lane_cnt is set to 0, and wr_ptr advances after the write.
  - Accept with last, or close of word at wr_ptr==RAM_DEPTH-1: go to FLUSH and latch n_words = wr_ptr+1. Latch term_last = s_pix_last.
- Write-pending cycle: bram_ena=1, bram_wea=1, bram_addra=wr_ptr, bram_dina=word register. It occurs in the cycle after the closing accept, in FILL or FLUSH. Pixels may keep arriving during it. No two writes collide, because the next close is ≥1 cycle later.
- FLUSH: the final pending write executes. Next state is RD with rd_ptr=0.
- RD: bram_ena=1, bram_wea=0, bram_addra=rd_ptr. Next state is OUT.
- OUT: m_tvalid=1, m_tdata=bram_douta (held because ena is low), m_tlast=(rd_ptr==n_words-1).
  - On tready, the last word goes to DONE. Any other word increments rd_ptr and goes to RD.
- DONE: tile_done = term_last for one cycle. wr_ptr, rd_ptr and lane_cnt are cleared. Next state is FILL.
- A full chunk without last drains with tlast on word RAM_DEPTH, with no tile_done. Subsequent pixels start a new chunk at address 0.
- BRAM port signals are combinational decodes of state and registers only. There is no s_* or m_tready to BRAM path.

## Timing
- Reset: async assert. All registers are 0, state is IDLE. s_pix_ready, m_tvalid, m_tlast, tile_done, bram_ena and bram_wea are 0, bram_addra and bram_dina are 0. BRAM contents are untouched.
- First cycle after reset release: IDLE. s_pix_ready goes high the following cycle.
- Fill throughput is 1 pixel/cycle. Write latency is 1 cycle after the closing accept.
- Closing accept with last at cycle t: FLUSH at t+1 (write), RD at t+2, first m_tvalid at t+3.
- Drain throughput is 1 word per 2 cycles with tready held high. Backpressure holds tdata, tvalid and tlast stable.
- s_pix_ready is 0 from FLUSH through DONE.
- Reset mid-drain: m_tvalid drops asynchronously. The partial chunk is discarded.

## Structure
- Shared package: DATA_W, LANES, RAM_WIDTH, RAM_DEPTH, ADDR_W, and the state encoding enum.
- No sub-module; the BRAM is instantiated beside this block by the parent.

## Test plan
- 8 pixels 0x01..0x08, last on the 8th: one write, addr 0, dina 0x0807060504030201. One beat with tlast=1, then tile_done pulses once.
- 3 pixels 0xAA, 0xBB, 0xCC with last: write 0x0000000000CCBBAA at addr 0. One beat with tlast.
- 9 pixels 0x01..0x09, last on the 9th: writes at addr 0 and addr 1 (0x0000000000000009). Two beats, tlast on the 2nd.
- 80 pixels, no last: writes at addr 0..9. ready falls after the 80th pixel. 10 beats with tlast on the 10th, no tile_done, then ready returns high.
- tready held low 5 cycles mid-drain: tdata and tvalid stable throughout. No word skipped or duplicated.
- rsta pulsed in OUT: tvalid=0 immediately. IDLE, then FILL with ready=1 on the 2nd cycle after release. A new 8-pixel tile drains correctly.

Source files
------------

// File: rtl/ofm_pack_drain_pkg.sv
// Shared constants and state encoding for the OFM pack/drain controller.
//   DATA_W    : pixel width
//   LANES     : pixels packed per BRAM word
//   RAM_WIDTH : BRAM word width (DATA_W*LANES)
//   RAM_DEPTH : BRAM entries per chunk
//   ADDR_W    : BRAM address width
package ofm_pack_drain_pkg;

    localparam int DATA_W    = 8;
    localparam int LANES     = 8;
    localparam int RAM_WIDTH = DATA_W * LANES;
    localparam int RAM_DEPTH = 10;
    localparam int ADDR_W    = $clog2(RAM_DEPTH);
    localparam int LANE_W    = $clog2(LANES);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_RD    = 3'd3,
        ST_OUT   = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/ofm_pack_drain.sv
// Owns port A of the OFM BRAM. Packs the 8-bit pixel stream into 64-bit
// words written at consecutive addresses; on tile end or buffer full the
// words are read back and drained to a 64-bit AXI-Stream master.
//   clka, rsta                          : clock, async active-high reset
//   s_pix_data/valid/last/ready         : pixel input stream
//   bram_addra/dina/wea/ena/regcea      : BRAM port A controls
//   bram_douta                          : BRAM read data (1-cycle latency)
//   m_tdata/tvalid/tlast/tready         : drained word stream
//   tile_done                           : pulse after a last-terminated chunk drains
module ofm_pack_drain
    import ofm_pack_drain_pkg::*;
(
    input  logic                 clka,
    input  logic                 rsta,
    input  logic [DATA_W-1:0]    s_pix_data,
    input  logic                 s_pix_valid,
    input  logic                 s_pix_last,
    output logic                 s_pix_ready,
    output logic [ADDR_W-1:0]    bram_addra,
    output logic [RAM_WIDTH-1:0] bram_dina,
    output logic                 bram_wea,
    output logic                 bram_ena,
    output logic                 bram_regcea,
    input  logic [RAM_WIDTH-1:0] bram_douta,
    output logic [RAM_WIDTH-1:0] m_tdata,
    output logic                 m_tvalid,
    output logic                 m_tlast,
    input  logic                 m_tready,
    output logic                 tile_done
);

    state_e               state_q, state_d;
    logic [LANE_W-1:0]    lane_q, lane_d;
    logic [RAM_WIDTH-1:0] pack_q, pack_d;
    logic [RAM_WIDTH-1:0] word_q, word_d;
    logic                 wr_pend_q, wr_pend_d;
    logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]    n_words_q, n_words_d;
    logic                 term_q, term_d;

    logic [ADDR_W-1:0]    wr_ptr_eff;
    logic [RAM_WIDTH-1:0] lane_word;

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state_q   <= ST_IDLE;
            lane_q    <= '0;
            pack_q    <= '0;
            word_q    <= '0;
            wr_pend_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            n_words_q <= '0;
            term_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            pack_q    <= pack_d;
            word_q    <= word_d;
            wr_pend_q <= wr_pend_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            n_words_q <= n_words_d;
            term_q    <= term_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        pack_d      = pack_q;
        word_d      = word_q;
        wr_pend_d   = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        n_words_d   = n_words_q;
        term_d      = term_q;
        s_pix_ready = 1'b0;
        m_tvalid    = 1'b0;
        m_tlast     = 1'b0;
        m_tdata     = '0;
        tile_done   = 1'b0;

        // A write still pending this cycle has not yet advanced wr_ptr_q, so
        // the word being closed now lands one address further on.
        wr_ptr_eff = wr_ptr_q + (wr_pend_q ? ADDR_W'(1) : ADDR_W'(0));
        lane_word  = pack_q;
        lane_word[lane_q*DATA_W +: DATA_W] = s_pix_data;

        if (wr_pend_q) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end

        unique case (state_q)
            ST_IDLE: state_d = ST_FILL;
            ST_FILL: begin
                s_pix_ready = 1'b1;
                if (s_pix_valid) begin
                    if (lane_q == LANE_W'(LANES-1) || s_pix_last) begin
                        word_d    = lane_word;
                        wr_pend_d = 1'b1;
                        pack_d    = '0;
                        lane_d    = '0;
                        if (s_pix_last || wr_ptr_eff == ADDR_W'(RAM_DEPTH-1)) begin
                            state_d   = ST_FLUSH;
                            n_words_d = wr_ptr_eff + ADDR_W'(1);
                            term_d    = s_pix_last;
                        end
                    end else begin
                        pack_d = lane_word;
                        lane_d = lane_q + LANE_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                state_d  = ST_RD;
                rd_ptr_d = '0;
            end
            ST_RD: state_d = ST_OUT;
            ST_OUT: begin
                m_tvalid = 1'b1;
                m_tdata  = bram_douta;
                m_tlast  = (rd_ptr_q == n_words_q - ADDR_W'(1));
                if (m_tready) begin
                    if (m_tlast) begin
                        state_d = ST_DONE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                        state_d  = ST_RD;
                    end
                end
            end
            ST_DONE: begin
                tile_done = term_q;
                wr_ptr_d  = '0;
                rd_ptr_d  = '0;
                lane_d    = '0;
                state_d   = ST_FILL;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // BRAM port is decoded from registered state only.
    always_comb begin
        bram_regcea = 1'b1;
        bram_ena    = wr_pend_q || (state_q == ST_RD);
        bram_wea    = wr_pend_q;
        bram_dina   = wr_pend_q ? word_q : '0;
        if (wr_pend_q) begin
            bram_addra = wr_ptr_q;
        end else if (state_q == ST_RD) begin
            bram_addra = rd_ptr_q;
        end else begin
            bram_addra = '0;
        end
    end

endmodule

// File: tb/tb_ofm_pack_drain.sv
// Scoreboard bench for ofm_pack_drain: expected BRAM writes and stream beats
// are queued by the stimulus, a negedge monitor pops and compares them.
module tb_ofm_pack_drain;
    import ofm_pack_drain_pkg::*;

    logic                 clka = 1'b0;
    logic                 rsta = 1'b1;
    logic [DATA_W-1:0]    s_pix_data = '0;
    logic                 s_pix_valid = 1'b0;
    logic                 s_pix_last = 1'b0;
    logic                 s_pix_ready;
    logic [ADDR_W-1:0]    bram_addra;
    logic [RAM_WIDTH-1:0] bram_dina;
    logic                 bram_wea;
    logic                 bram_ena;
    logic                 bram_regcea;
    logic [RAM_WIDTH-1:0] bram_douta = '0;
    logic [RAM_WIDTH-1:0] m_tdata;
    logic                 m_tvalid;
    logic                 m_tlast;
    logic                 m_tready = 1'b1;
    logic                 tile_done;

    int errors = 0;
    int checks = 0;
    int beats_seen = 0;

    logic [RAM_WIDTH-1:0] mem [0:15];
    logic [ADDR_W+RAM_WIDTH-1:0] wr_q[$];   // {addr, data}
    logic [RAM_WIDTH+1:0]        beat_q[$]; // {done, last, data}
    logic chk_done = 1'b0;
    logic exp_done = 1'b0;

    always #5 clka = ~clka;

    ofm_pack_drain dut (
        .clka(clka), .rsta(rsta),
        .s_pix_data(s_pix_data), .s_pix_valid(s_pix_valid),
        .s_pix_last(s_pix_last), .s_pix_ready(s_pix_ready),
        .bram_addra(bram_addra), .bram_dina(bram_dina), .bram_wea(bram_wea),
        .bram_ena(bram_ena), .bram_regcea(bram_regcea), .bram_douta(bram_douta),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
        .m_tready(m_tready), .tile_done(tile_done)
    );

    // Single-port BRAM model: write-or-read per enabled cycle.
    always @(posedge clka) begin
        if (bram_ena) begin
            if (bram_wea) mem[bram_addra] <= bram_dina;
            else          bram_douta <= mem[bram_addra];
        end
    end

    task automatic chk(input string name, input logic [RAM_WIDTH-1:0] act,
                       input logic [RAM_WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clka) begin
        logic [ADDR_W+RAM_WIDTH-1:0] w;
        logic [RAM_WIDTH+1:0]        b;
        if (!rsta) begin
            if (chk_done) begin
                chk("tile_done", 64'(tile_done), 64'(exp_done));
                chk_done = 1'b0;
            end else if (tile_done) begin
                chk("unexpected_tile_done", 64'(tile_done), 64'd0);
            end
            if (bram_ena && bram_wea) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", 64'(bram_addra), 64'hFFFF);
                end else begin
                    w = wr_q.pop_front();
                    chk("wr_addr", 64'(bram_addra), 64'(w[ADDR_W+RAM_WIDTH-1:RAM_WIDTH]));
                    chk("wr_data", bram_dina, w[RAM_WIDTH-1:0]);
                end
            end
            if (m_tvalid && m_tready) begin
                beats_seen++;
                if (beat_q.size() == 0) begin
                    chk("unexpected_beat", m_tdata, 64'hDEAD);
                end else begin
                    b = beat_q.pop_front();
                    chk("tdata", m_tdata, b[RAM_WIDTH-1:0]);
                    chk("tlast", 64'(m_tlast), 64'(b[RAM_WIDTH]));
                    if (b[RAM_WIDTH]) begin
                        chk_done = 1'b1;
                        exp_done = b[RAM_WIDTH+1];
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int n;
        s_pix_valid = 1'b1;
        s_pix_data  = d;
        s_pix_last  = l;
        n = 0;
        while (!s_pix_ready && n < 50) begin
            tick();
            n++;
        end
        if (!s_pix_ready) chk("ready_timeout", 64'(s_pix_ready), 64'd1);
        tick();
    endtask

    task automatic send_seq(input logic [7:0] start, input int n, input logic l);
        for (int i = 0; i < n; i++) begin
            send(start + 8'(i), l && (i == n - 1));
        end
        s_pix_valid = 1'b0;
        s_pix_last  = 1'b0;
    endtask

    task automatic push_wr(input int a, input logic [RAM_WIDTH-1:0] d);
        wr_q.push_back({ADDR_W'(a), d});
    endtask

    task automatic push_beat(input logic done, input logic last, input logic [RAM_WIDTH-1:0] d);
        beat_q.push_back({done, last, d});
    endtask

    // Expectations for a run of consecutive pixel values start, start+1, ...
    task automatic push_seq(input logic [7:0] start, input int n, input logic l);
        int nw;
        logic [RAM_WIDTH-1:0] word;
        nw = (n + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            word = '0;
            for (int k = 0; k < 8; k++) begin
                if (w*8 + k < n) word[k*8 +: 8] = start + 8'(w*8 + k);
            end
            push_wr(w, word);
            push_beat(l, w == nw - 1, word);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((beat_q.size() != 0 || wr_q.size() != 0 || chk_done) && n < 400) begin
            tick();
            n++;
        end
        chk("drain_timeout", 64'(beat_q.size() + wr_q.size()), 64'd0);
        tick();
        tick();
    endtask

    initial begin
        int n;
        // Reset state
        #12;
        chk("rst_ready", 64'(s_pix_ready), 64'd0);
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_tlast", 64'(m_tlast), 64'd0);
        chk("rst_done", 64'(tile_done), 64'd0);
        chk("rst_ena_wea", 64'({bram_ena, bram_wea}), 64'd0);
        chk("rst_addr", 64'(bram_addra), 64'd0);
        chk("rst_dina", bram_dina, 64'd0);
        chk("regcea", 64'(bram_regcea), 64'd1);
        @(posedge clka); #1;
        rsta = 1'b0;
        chk("idle_ready", 64'(s_pix_ready), 64'd0);
        tick();
        chk("fill_ready", 64'(s_pix_ready), 64'd1);

        // T1: 8 pixels with last, plus latency
        push_wr(0, 64'h0807060504030201);
        push_beat(1'b1, 1'b1, 64'h0807060504030201);
        send_seq(8'h01, 8, 1'b1);
        chk("t1_flush_ready", 64'(s_pix_ready), 64'd0);
        chk("t1_flush_wea", 64'(bram_wea), 64'd1);
        tick();
        chk("t1_rd_tvalid", 64'(m_tvalid), 64'd0);
        chk("t1_rd_ena_wea", 64'({bram_ena, bram_wea}), 64'b10);
        tick();
        chk("t1_out_tvalid", 64'(m_tvalid), 64'd1);
        wait_drain();

        // T2: 3 pixels with last
        push_wr(0, 64'h0000000000CCBBAA);
        push_beat(1'b1, 1'b1, 64'h0000000000CCBBAA);
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b1);
        s_pix_valid = 1'b0; s_pix_last = 1'b0;
        wait_drain();

        // T3: 9 pixels with last
        push_wr(0, 64'h0807060504030201);
        push_wr(1, 64'h0000000000000009);
        push_beat(1'b0, 1'b0, 64'h0807060504030201);
        push_beat(1'b1, 1'b1, 64'h0000000000000009);
        send_seq(8'h01, 9, 1'b1);
        wait_drain();

        // T4: full chunk, no last
        push_seq(8'h00, 80, 1'b0);
        send_seq(8'h00, 80, 1'b0);
        chk("t4_ready_low", 64'(s_pix_ready), 64'd0);
        wait_drain();
        chk("t4_ready_back", 64'(s_pix_ready), 64'd1);

        // T5: backpressure mid-drain (3 words)
        push_seq(8'h10, 24, 1'b1);
        send_seq(8'h10, 24, 1'b1);
        n = beats_seen;
        for (int i = 0; i < 60 && beats_seen == n; i++) tick();
        m_tready = 1'b0;
        for (int i = 0; i < 10 && !m_tvalid; i++) tick();
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_tvalid", 64'(m_tvalid), 64'd1);
            chk("t5_hold_tdata", m_tdata, 64'h1F1E1D1C1B1A1918);
            chk("t5_hold_tlast", 64'(m_tlast), 64'd0);
            tick();
        end
        m_tready = 1'b1;
        wait_drain();

        // T6: reset in OUT
        m_tready = 1'b0;
        push_seq(8'h01, 8, 1'b1);
        send_seq(8'h01, 8, 1'b1);
        for (int i = 0; i < 10 && !m_tvalid; i++) tick();
        chk("t6_in_out", 64'(m_tvalid), 64'd1);
        #2;
        rsta = 1'b1;
        beat_q.delete();
        wr_q.delete();
        chk_done = 1'b0;
        #1;
        chk("t6_async_tvalid", 64'(m_tvalid), 64'd0);
        tick();
        tick();
        rsta = 1'b0;
        m_tready = 1'b1;
        chk("t6_idle_ready", 64'(s_pix_ready), 64'd0);
        tick();
        chk("t6_fill_ready", 64'(s_pix_ready), 64'd1);
        push_wr(0, 64'h1817161514131211);
        push_beat(1'b1, 1'b1, 64'h1817161514131211);
        send_seq(8'h11, 8, 1'b1);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
